r_tile_queue_bank: RTL and testbench
====================================

Name: r_tile_queue_bank

Overview:
- Register-bank responder for the E-tile register request interface (`read_req`/`write_req` -> `ack_reg`/`alignment_err`/`read_data`).
- Holds one interleaved bank of the 128 G registers: 32 architectural entries.
- Holds a 32-entry write queue of uncommitted block writes, with read forwarding.
- The G-tile commits the queue to architectural state, or flushes it, per block.

Parameters:
- BANK_ID, 0, bank index; this bank owns every `reg_id` with `reg_id[1:0] == BANK_ID`.
- DATA_W, 64, register/operand data width.
- WQ_DEPTH, 32, write-queue entries; fixed at 32 to match the 5-bit `queue_id`.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- read_req  in  1  read request from E-tile
- write_req  in  1  write request from E-tile
- reg_id  in  7  G register number [0-127]
- queue_id  in  5  W queue slot for writes
- write_data  in  DATA_W  write value
- read_data  out  DATA_W  read result
- ack_reg  out  1  request accepted/serviced
- alignment_err  out  1  `reg_id` not owned by this bank
- commit_req  in  1  G-tile: commit write queue (level, sampled in IDLE)
- flush_req  in  1  G-tile: discard write queue
- commit_busy  out  1  high while in COMMIT
- commit_done  out  1  one-cycle pulse at commit completion

Behaviour:
- Reset (async, `rst=1`):
  - All outputs 0.
  - All 32 architectural registers 0.
  - All write-queue valid bits 0.
  - FSM = IDLE, commit counter = 0.
- Register index: `idx = reg_id[6:2]`. A request is aligned iff `reg_id[1:0] == BANK_ID`.
- Response latency: all responses are registered, 1 cycle after the request cycle. `ack_reg`, `alignment_err` and `commit_done` are single-cycle pulses.
- IDLE, `write_req` aligned:
  - `wq[queue_id] <= {valid=1, idx, write_data}`.
  - `ack_reg=1` next cycle.
  - A rewrite of an already-valid slot overwrites it.
- IDLE, `read_req` aligned:
  - Search all valid wq entries whose idx matches.
  - On a hit, return the entry with the highest `queue_id` (latest in program order).
  - Otherwise return `arch[idx]`.
  - `read_data` and `ack_reg=1` appear next cycle.
- Misaligned read or write:
  - Next cycle `ack_reg=1`, `alignment_err=1`, `read_data=0`.
  - No state change.
- `read_req` and `write_req` in the same cycle:
  - Both are serviced with a single `ack_reg` pulse.
  - The read observes queue state before this cycle's write; there is no same-cycle bypass.
  - `alignment_err` is the OR of the two checks; only aligned parts take effect.
- `read_data` holds its last value except when updated by a read or cleared by an error.
- COMMIT state:
  - Entered from IDLE when `commit_req=1` and `flush_req=0`; `commit_busy=1`.
  - Counter c runs 0..31, one per cycle. If `wq[c].valid`, then `arch[wq[c].idx] <= wq[c].data` and `wq[c].valid <= 0`.
  - Processing is in ascending order, so a later slot wins for the same idx.
  - Takes exactly 32 cycles. After c=31 the FSM goes to IDLE, with `commit_done=1` and `commit_busy=0` the following cycle.
  - Read/write requests during COMMIT are not acknowledged: `ack_reg=0`, `alignment_err=0`, no state change. The initiator retries.
- Flush:
  - `flush_req=1` in any state clears all wq valid bits in one cycle and forces FSM = IDLE.
  - Flush aborts a commit in progress: entries already committed stay in arch, no `commit_done`.
  - Flush wins over a simultaneous `commit_req`, read or write; the request is not acked.
- `commit_req` held high after completion starts a new commit; the G-tile deasserts it on `commit_done`.
- Reset mid-commit: immediate return to reset state; arch is cleared.

Test Plan:
- BANK_ID=1:
  - `write_req reg_id=5 queue_id=3 data=0xAA` -> next cycle `ack_reg=1`, `alignment_err=0`.
  - Then `read_req reg_id=5` -> `read_data=0xAA`, `ack_reg=1` (forwarded; arch[1] still 0).
- Forwarding priority:
  - Write `reg_id=9` data 0x11 at `queue_id=2`, then data 0x22 at `queue_id=7`.
  - Read `reg_id=9` -> 0x22.
  - Commit, then flush, then read -> 0x22 from arch.
- Misalignment (BANK_ID=1): `read_req reg_id=6` -> `ack_reg=1`, `alignment_err=1`, `read_data=0`; no state change.
- Commit timing:
  - `commit_req` 1 cycle with 3 valid entries -> `commit_busy` high 32 cycles, `commit_done` pulse in the cycle after.
  - A `write_req` during COMMIT gets no ack; a retry after done is acked.
- Flush:
  - Write `reg_id=13` 0x55, flush, read `reg_id=13` -> 0 (arch).
  - Flush at commit cycle 10 -> no `commit_done`; slots 0-9 committed, slots 10+ discarded.
- Simultaneous access:
  - Same cycle: `write_req reg_id=1 data 0x77` and `read_req reg_id=1` (queue empty) -> one `ack_reg`, `read_data=0`.
  - Subsequent read -> 0x77.
- Async reset mid-commit -> all outputs 0 immediately; reads after reset return 0.

Source files
------------

// File: rtl/r_tile_queue_bank.sv
// Register bank for one interleave of the 128 G registers, with a 32-slot
// write queue that forwards to reads and is committed or flushed per block.
module r_tile_queue_bank #(
    parameter int BANK_ID  = 0,
    parameter int DATA_W   = 64,
    parameter int WQ_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [6:0]        reg_id,
    input  logic [4:0]        queue_id,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              ack_reg,
    output logic              alignment_err,
    input  logic              commit_req,
    input  logic              flush_req,
    output logic              commit_busy,
    output logic              commit_done
);

    typedef enum logic {IDLE, COMMIT} state_t;

    localparam logic [1:0] BANK = BANK_ID[1:0];

    state_t            state, state_nxt;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] arch    [32];
    logic [WQ_DEPTH-1:0] wq_valid;
    logic [4:0]        wq_idx  [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data [WQ_DEPTH];

    logic [4:0]        idx;
    logic              aligned, svc, wr_en, rd_en, err, commit_step;
    logic [DATA_W-1:0] fwd_data;

    assign idx         = reg_id[6:2];
    assign aligned     = (reg_id[1:0] == BANK);
    assign svc         = (state == IDLE) && !flush_req && (read_req || write_req);
    assign wr_en       = svc && write_req && aligned;
    assign rd_en       = svc && read_req && aligned;
    assign err         = svc && !aligned;
    assign commit_step = (state == COMMIT) && !flush_req;

    // Highest matching queue slot is the youngest write, so the last hit wins.
    always_comb begin
        fwd_data = arch[idx];
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (wq_valid[i] && wq_idx[i] == idx) fwd_data = wq_data[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (commit_req && !flush_req) state_nxt = COMMIT;
            COMMIT: if (flush_req || cnt == 5'd31) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        commit_busy = (state == COMMIT);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt <= '0;
        else if (commit_step) cnt <= cnt + 5'd1;
        else                  cnt <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wq_valid <= '0;
        end else if (flush_req) begin
            wq_valid <= '0;
        end else begin
            if (commit_step && wq_valid[cnt]) wq_valid[cnt] <= 1'b0;
            if (wr_en) wq_valid[queue_id] <= 1'b1;
        end
    end

    // NOTE: queue payload needs no reset; it is only observed behind wq_valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            wq_idx[queue_id]  <= idx;
            wq_data[queue_id] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) arch[i] <= '0;
        end else if (commit_step && wq_valid[cnt]) begin
            arch[wq_idx[cnt]] <= wq_data[cnt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_reg       <= 1'b0;
            alignment_err <= 1'b0;
            commit_done   <= 1'b0;
            read_data     <= '0;
        end else begin
            ack_reg       <= svc;
            alignment_err <= err;
            commit_done   <= commit_step && (cnt == 5'd31);
            if (err)        read_data <= '0;
            else if (rd_en) read_data <= fwd_data;
        end
    end

endmodule

// File: tb/tb_r_tile_queue_bank.sv
// Directed bench for r_tile_queue_bank with BANK_ID=1: forwarding, alignment,
// commit timing, flush (idle and mid-commit), simultaneous access, reset.
module tb_r_tile_queue_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_req, write_req, commit_req, flush_req;
    logic [6:0]  reg_id;
    logic [4:0]  queue_id;
    logic [63:0] write_data, read_data;
    logic        ack_reg, alignment_err, commit_busy, commit_done;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt, done_at, done_cnt;

    r_tile_queue_bank #(.BANK_ID(1), .DATA_W(64), .WQ_DEPTH(32)) dut (
        .clk(clk), .rst(rst),
        .read_req(read_req), .write_req(write_req),
        .reg_id(reg_id), .queue_id(queue_id), .write_data(write_data),
        .read_data(read_data), .ack_reg(ack_reg), .alignment_err(alignment_err),
        .commit_req(commit_req), .flush_req(flush_req),
        .commit_busy(commit_busy), .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle request; on return the registered response is visible.
    task automatic do_req(input logic rd, input logic wr, input logic [6:0] id,
                          input logic [4:0] q, input logic [63:0] d);
        @(negedge clk);
        read_req = rd; write_req = wr; reg_id = id; queue_id = q; write_data = d;
        @(negedge clk);
        read_req = 1'b0; write_req = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk); flush_req = 1'b1;
        @(negedge clk); flush_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; read_req = 0; write_req = 0; commit_req = 0; flush_req = 0;
        reg_id = '0; queue_id = '0; write_data = '0;
        #3;
        check("reset_outs", {read_data[7:0], ack_reg, alignment_err, commit_busy, commit_done}, 0);
        @(negedge clk); rst = 1'b0;

        // Aligned write, then forwarded read
        do_req(0, 1, 7'd5, 5'd3, 64'hAA);
        check("wr_ack", ack_reg, 1);
        check("wr_err", alignment_err, 0);
        do_req(1, 0, 7'd5, 5'd0, 64'h0);
        check("fwd_rd", read_data, 64'hAA);
        check("fwd_ack", ack_reg, 1);

        // Forwarding priority: higher queue slot wins
        do_req(0, 1, 7'd9, 5'd2, 64'h11);
        do_req(0, 1, 7'd9, 5'd7, 64'h22);
        do_req(1, 0, 7'd9, 5'd0, 64'h0);
        check("fwd_prio", read_data, 64'h22);

        // Misaligned read
        do_req(1, 0, 7'd6, 5'd0, 64'h0);
        check("mis_ack", ack_reg, 1);
        check("mis_err", alignment_err, 1);
        check("mis_rd", read_data, 0);
        do_req(1, 0, 7'd5, 5'd0, 64'h0);
        check("mis_nochg", read_data, 64'hAA);

        // Commit with 3 valid entries; write during commit must be ignored
        @(negedge clk); commit_req = 1'b1;
        @(negedge clk); commit_req = 1'b0;
        busy_cnt = 0; done_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (commit_done) begin
                done_at = k;
                check("done_busy", commit_busy, 0);
                break;
            end
            if (commit_busy) busy_cnt++;
            if (k == 5) begin
                write_req = 1'b1; reg_id = 7'd13; queue_id = 5'd5; write_data = 64'h55;
            end
            if (k == 6) begin
                write_req = 1'b0;
                check("commit_noack", ack_reg, 0);
            end
            @(negedge clk);
        end
        check("busy_cycles", busy_cnt, 32);
        check("done_at", done_at, 32);
        @(negedge clk);
        check("done_pulse", commit_done, 0);
        do_req(1, 0, 7'd13, 5'd0, 64'h0);
        check("commit_wr_dropped", read_data, 0);

        // Retry after done, then flush discards it; arch keeps committed values
        do_req(0, 1, 7'd13, 5'd5, 64'h55);
        check("retry_ack", ack_reg, 1);
        pulse_flush();
        do_req(1, 0, 7'd9, 5'd0, 64'h0);
        check("arch_rd9", read_data, 64'h22);
        do_req(1, 0, 7'd13, 5'd0, 64'h0);
        check("flush_rd13", read_data, 0);

        // Simultaneous read and write, queue empty
        do_req(1, 1, 7'd1, 5'd0, 64'h77);
        check("sim_ack", ack_reg, 1);
        check("sim_rd", read_data, 0);
        @(negedge clk);
        check("sim_single_ack", ack_reg, 0);
        do_req(1, 0, 7'd1, 5'd0, 64'h0);
        check("sim_after", read_data, 64'h77);

        // Fill all slots (slot q -> idx q), flush at commit cycle 10
        for (int q = 0; q < 32; q++) begin
            do_req(0, 1, 7'(4 * q + 1), 5'(q), 64'h100 + 64'(q));
        end
        @(negedge clk); commit_req = 1'b1;
        @(negedge clk); commit_req = 1'b0;
        repeat (10) @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk); flush_req = 1'b0;
        check("flush_busy", commit_busy, 0);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (commit_done) done_cnt++;
            @(negedge clk);
        end
        check("flush_no_done", done_cnt, 0);
        do_req(1, 0, 7'd1, 5'd0, 64'h0);
        check("abort_slot0", read_data, 64'h100);
        do_req(1, 0, 7'd37, 5'd0, 64'h0);
        check("abort_slot9", read_data, 64'h109);
        do_req(1, 0, 7'd41, 5'd0, 64'h0);
        check("abort_slot10", read_data, 0);
        do_req(1, 0, 7'd125, 5'd0, 64'h0);
        check("abort_slot31", read_data, 0);

        // Async reset mid-commit
        do_req(1, 0, 7'd37, 5'd0, 64'h0);
        @(negedge clk); commit_req = 1'b1;
        @(negedge clk); commit_req = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", commit_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_outs", {read_data, ack_reg, alignment_err, commit_busy, commit_done}, 0);
        @(negedge clk); rst = 1'b0;
        do_req(1, 0, 7'd37, 5'd0, 64'h0);
        check("rst_rd37", read_data, 0);
        do_req(1, 0, 7'd5, 5'd0, 64'h0);
        check("rst_rd5", read_data, 0);
        check("rst_rd_ack", ack_reg, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
